ps2_host_tx: RTL and testbench
==============================

PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter INHIBIT_CYCLES, default 5000, clk cycles ps2_clk is held low for request-to-send (100 us at 50 MHz).
REQ-002 Parameter TIMEOUT_CYCLES, default 750000, watchdog limit in clk cycles (15 ms at 50 MHz); used only under PS2_TX_TIMEOUT_EN.
REQ-003 clk  input  1  system clock; every register is clocked on its rising edge.
REQ-004 clr  input  1  synchronous active-high reset.
REQ-005 ps2_clk  input  1  PS/2 clock line as read back from the pin (asynchronous).
REQ-006 ps2_data  input  1  PS/2 data line as read back from the pin (asynchronous).
REQ-007 ps2_clk_oe  output  1  1 = pull ps2_clk low (open-drain), 0 = release.
REQ-008 ps2_data_oe  output  1  1 = pull ps2_data low (open-drain), 0 = release.
REQ-009 data_in  input  8  command byte to send to the device.
REQ-010 send  input  1  request strobe; sampled only in IDLE.
REQ-011 busy  output  1  high from the cycle after an accepted send until the cycle done is asserted.
REQ-012 done  output  1  one-cycle pulse at end of every transfer, successful or not.
REQ-013 err  output  1  valid with done: 1 = no device ACK (or timeout); held until next accepted send.

Function
REQ-014 ps2_clk SHALL pass through a 3-stage synchronizer; falling edge = sync[2] & ~sync[1]; ps2_data SHALL be 2-stage synchronized.
REQ-015 States: IDLE, INHIBIT, START, DATA, PARITY, STOP, ACK, WAIT_IDLE.
REQ-016 IDLE: send=1 latches data_in, computes odd parity (~^data_in), clears bit counter and err, enters INHIBIT; busy rises the next cycle.
REQ-017 INHIBIT: ps2_clk_oe=1 for INHIBIT_CYCLES cycles; ps2_data_oe=1 asserted during the final cycle; then START.
REQ-018 START: ps2_clk_oe=0, ps2_data_oe=1 (start bit 0); first ps2_clk falling edge enters DATA and drives bit0.
REQ-019 DATA: on each falling edge, drive next data bit LSB first (ps2_data_oe = ~bit); after the edge that drives bit7, next falling edge drives parity and enters PARITY.
REQ-020 PARITY: next falling edge releases ps2_data (stop bit 1), enters STOP.
REQ-021 STOP: next falling edge samples synchronized ps2_data; 0 = ACK, err=0; 1 = err=1; enters WAIT_IDLE.
REQ-022 WAIT_IDLE: both lines released; when synchronized ps2_clk and ps2_data are both 1, pulse done for one cycle, drop busy, return to IDLE.
REQ-023 Total: exactly 11 device falling edges per transfer after START; data changes only in the cycle following a detected falling edge.
REQ-024 send while busy SHALL be ignored; data_in changes while busy SHALL not affect the frame in flight.
REQ-025 send asserted in the same cycle done pulses SHALL be ignored (state is not IDLE yet); accepted on the following cycle if still high.
REQ-026 Outside INHIBIT/START/DATA/PARITY, ps2_clk_oe=0; ps2_data_oe=0 in IDLE, STOP, ACK, WAIT_IDLE.

Reset
REQ-027 clr=1 SHALL force IDLE, ps2_clk_oe=0, ps2_data_oe=0, busy=0, done=0, err=0, counters=0 on the next clk edge.
REQ-028 clr mid-transfer SHALL release both lines immediately (next edge) with no done pulse.

Configuration
REQ-029 Macro PS2_TX_TIMEOUT_EN defined: watchdog counter cleared on entering START and on each falling edge; reaching TIMEOUT_CYCLES in START..STOP releases both lines, sets err=1, pulses done, returns to IDLE.
REQ-030 PS2_TX_TIMEOUT_EN undefined: no watchdog logic; block waits indefinitely for device edges; TIMEOUT_CYCLES unused.

Verification
REQ-031 INHIBIT_CYCLES=20, send with data_in=0xED, device model clocks 11 edges and ACKs -> data bits 1,0,1,1,0,1,1,1, parity 1, stop 1, done pulse, err=0.
REQ-032 data_in=0x01, device samples on rising edges -> received byte 0x01, parity 0; data_in=0x00 -> parity 1.
REQ-033 Device releases data at ACK edge (ps2_data=1) -> done pulse with err=1; next send 0xF4 with ACK -> err=0.
REQ-034 send pulsed 3 times during busy with data_in=0xAA -> single frame of original byte 0xED, exactly one done.
REQ-035 clr asserted after 5th falling edge -> next cycle ps2_clk_oe=0, ps2_data_oe=0, busy=0, no done; following send completes normally.
REQ-036 PS2_TX_TIMEOUT_EN defined, TIMEOUT_CYCLES=100, device stops after 4 edges -> lines released, done with err=1 exactly 100 cycles after last edge.

Source files
------------

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter (optional watchdog: PS2_TX_TIMEOUT_EN)
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    input  logic [7:0] data_in,
    input  logic       send,
    output logic       busy,
    output logic       done,
    output logic       err
);
    localparam int IW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES + 1) : 1;

    typedef enum logic [2:0] {
        IDLE, INHIBIT, START, DATA, PARITY, STOP, ACK, WAIT_IDLE
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      clk_sync_q, clk_sync_d;
    logic [1:0]      data_sync_q, data_sync_d;
    logic [7:0]      shift_q, shift_d;
    logic            parity_q, parity_d;
    logic [2:0]      bit_q, bit_d;
    logic [IW-1:0]   inh_q, inh_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            fall;
    logic            clk_s;
    logic            data_s;

`ifdef PS2_TX_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    logic [TW-1:0]   wd_q, wd_d;
`endif

    assign fall   = clk_sync_q[2] & ~clk_sync_q[1];
    assign clk_s  = clk_sync_q[1];
    assign data_s = data_sync_q[1];

    always_comb begin
        state_d     = state_q;
        clk_sync_d  = {clk_sync_q[1:0], ps2_clk};
        data_sync_d = {data_sync_q[0], ps2_data};
        shift_d     = shift_q;
        parity_d    = parity_q;
        bit_d       = bit_q;
        inh_d       = inh_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = err_q;
`ifdef PS2_TX_TIMEOUT_EN
        wd_d        = wd_q + 1'b1;
`endif
        case (state_q)
            IDLE: begin
                // done_q still high means the previous transfer ended last cycle
                if (send && !done_q) begin
                    shift_d  = data_in;
                    parity_d = ~^data_in;
                    bit_d    = '0;
                    inh_d    = '0;
                    err_d    = 1'b0;
                    busy_d   = 1'b1;
                    state_d  = INHIBIT;
                end
            end
            INHIBIT: begin
                if (inh_q == IW'(INHIBIT_CYCLES - 1)) begin
                    state_d = START;
`ifdef PS2_TX_TIMEOUT_EN
                    wd_d    = '0;
`endif
                end else begin
                    inh_d = inh_q + 1'b1;
                end
            end
            START: begin
                if (fall) begin
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (fall) begin
                    if (bit_q == 3'd7) state_d = PARITY;
                    else               bit_d   = bit_q + 1'b1;
                end
            end
            PARITY: begin
                if (fall) state_d = STOP;
            end
            STOP: begin
                if (fall) begin
                    err_d   = data_s;
                    state_d = ACK;
                end
            end
            ACK: begin
                state_d = WAIT_IDLE;
            end
            WAIT_IDLE: begin
                if (clk_s && data_s) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef PS2_TX_TIMEOUT_EN
        if (fall) wd_d = '0;
        if ((state_q inside {START, DATA, PARITY, STOP}) && !fall &&
            (wd_q == TW'(TIMEOUT_CYCLES - 1))) begin
            err_d   = 1'b1;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q     <= IDLE;
            clk_sync_q  <= 3'b111;
            data_sync_q <= 2'b11;
            shift_q     <= '0;
            parity_q    <= 1'b0;
            bit_q       <= '0;
            inh_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
            wd_q        <= '0;
`endif
        end else begin
            state_q     <= state_d;
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            shift_q     <= shift_d;
            parity_q    <= parity_d;
            bit_q       <= bit_d;
            inh_q       <= inh_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
`ifdef PS2_TX_TIMEOUT_EN
            wd_q        <= wd_d;
`endif
        end
    end

    // Line drivers decode from state, so every change lands the cycle after a detected edge
    always_comb begin
        ps2_clk_oe  = (state_q == INHIBIT);
        ps2_data_oe = 1'b0;
        case (state_q)
            INHIBIT: ps2_data_oe = (inh_q == IW'(INHIBIT_CYCLES - 1));
            START:   ps2_data_oe = 1'b1;
            DATA:    ps2_data_oe = ~shift_q[bit_q];
            PARITY:  ps2_data_oe = ~parity_q;
            default: ps2_data_oe = 1'b0;
        endcase
    end

    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - directed bench for ps2_host_tx with an open-drain device model
module tb_ps2_host_tx;
    localparam int H = 10;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       send = 1'b0;
    logic       ps2_clk_oe, ps2_data_oe, busy, done, err;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       ps2_clk_line, ps2_data_line;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int last_fall = 0;
    logic err_at_done = 1'b0;

    assign ps2_clk_line  = ps2_clk_oe ? 1'b0 : dev_clk;
    assign ps2_data_line = (ps2_data_oe || !dev_data) ? 1'b0 : 1'b1;

    ps2_host_tx #(.INHIBIT_CYCLES(20), .TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .clr(clr), .ps2_clk(ps2_clk_line), .ps2_data(ps2_data_line),
        .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe), .data_in(data_in),
        .send(send), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (done) begin
            done_cnt    = done_cnt + 1;
            err_at_done = err;
            done_cyc    = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Device: rx[7:0] data, rx[8] parity, rx[9] stop; stops with clock low after n_edges < 11
    task automatic dev_frame(input int n_edges, input bit ack, input bit spam, output logic [9:0] rx);
        rx = '0;
        for (int i = 1; i <= n_edges; i++) begin
            if (i == 11 && ack) dev_data = 1'b0;
            repeat (H) @(negedge clk);
            dev_clk   = 1'b0;
            last_fall = cyc;
            if (i == n_edges && n_edges < 11) begin
                repeat (2) @(negedge clk);
                return;
            end
            repeat (H) @(negedge clk);
            if (spam && (i == 2 || i == 4 || i == 6)) begin
                data_in = 8'hAA;
                send    = 1'b1;
                @(negedge clk);
                send    = 1'b0;
            end
            if (i <= 10) rx[i-1] = ps2_data_line;
            dev_clk = 1'b1;
            if (i == 11) dev_data = 1'b1;
        end
    endtask

    task automatic start_send(input string tag, input logic [7:0] d);
        int n;
        @(negedge clk);
        data_in = d;
        send    = 1'b1;
        @(negedge clk);
        send    = 1'b0;
        check({tag, "_busy"}, busy, 1);
        n = 0;
        while (ps2_clk_oe && n < 1000) begin
            n++;
            @(negedge clk);
        end
        check({tag, "_inhibit_len"}, n, 20);
        check({tag, "_start_bit"}, ps2_data_line, 0);
    endtask

    task automatic wait_done(input string tag, input int start_cnt, input int limit);
        int t;
        t = 0;
        while (done_cnt == start_cnt && t < limit) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_done_seen"}, (t < limit), 1);
        repeat (20) @(negedge clk);
        check({tag, "_done_count"}, done_cnt - start_cnt, 1);
        check({tag, "_busy_end"}, busy, 0);
    endtask

    task automatic do_frame(input string tag, input logic [7:0] d, input bit ack, input bit spam,
                            input logic [7:0] exp_byte, input logic exp_par, input logic exp_err);
        logic [9:0] rx;
        int start_cnt;
        start_cnt = done_cnt;
        start_send(tag, d);
        dev_frame(11, ack, spam, rx);
        wait_done(tag, start_cnt, 300);
        check({tag, "_byte"}, rx[7:0], exp_byte);
        check({tag, "_parity"}, rx[8], exp_par);
        check({tag, "_stop"}, rx[9], 1);
        check({tag, "_err"}, err_at_done, exp_err);
        check({tag, "_err_held"}, err, exp_err);
    endtask

    initial begin
        logic [9:0] rx;
        int start_cnt;
        repeat (3) @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        check("rst_clk_oe", ps2_clk_oe, 0);
        check("rst_data_oe", ps2_data_oe, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);

        do_frame("ed", 8'hED, 1'b1, 1'b0, 8'hED, 1'b1, 1'b0);
        do_frame("x01", 8'h01, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0);
        do_frame("x00", 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        do_frame("noack", 8'h5A, 1'b0, 1'b0, 8'h5A, 1'b1, 1'b1);
        do_frame("f4", 8'hF4, 1'b1, 1'b0, 8'hF4, 1'b0, 1'b0);
        do_frame("spam", 8'hED, 1'b1, 1'b1, 8'hED, 1'b1, 1'b0);

        start_cnt = done_cnt;
        start_send("clr", 8'h3C);
        dev_frame(5, 1'b1, 1'b0, rx);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clr_clk_oe", ps2_clk_oe, 0);
        check("clr_data_oe", ps2_data_oe, 0);
        check("clr_busy", busy, 0);
        check("clr_err", err, 0);
        dev_clk = 1'b1;
        repeat (50) @(negedge clk);
        check("clr_no_done", done_cnt - start_cnt, 0);
        do_frame("after_clr", 8'h3C, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0);

`ifdef PS2_TX_TIMEOUT_EN
        start_cnt = done_cnt;
        start_send("wd", 8'h12);
        dev_frame(4, 1'b1, 1'b0, rx);
        wait_done("wd", start_cnt, 400);
        check("wd_err", err_at_done, 1);
        check("wd_delay_window", ((done_cyc - last_fall) >= 100) && ((done_cyc - last_fall) <= 104), 1);
        check("wd_clk_oe", ps2_clk_oe, 0);
        check("wd_data_oe", ps2_data_oe, 0);
        dev_clk = 1'b1;
        repeat (20) @(negedge clk);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end
endmodule
